pdetect_frame_pack: RTL and testbench

Downstream stage of the pattern-detecting stream monitor. It consumes the monitor's pass-through byte stream and detect pulse, discards bytes while hunting for sync, then packs the next `PAYLOAD_BYTES` bytes big-endian into 32-bit words. Words are emitted on a ready/valid stream, and the final word of each frame is flagged. It also counts completed frames and flags resyncs that abort a frame.

---
 rtl/pdetect_pkg.sv | 23 ++
 rtl/stream_out_reg.sv | 41 ++++
 rtl/pdetect_frame_pack.sv | 113 +++++++++++
 tb/tb_pdetect_frame_pack.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdetect_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pdetect_pkg
//  Brief    : Shared types and helpers for the pattern-detect stream stages.
//  Revision : 1.0  initial release
// ============================================================================
package pdetect_pkg;

    // Framing state of the sync hunter / payload packer
    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } frame_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Width of a byte index able to count 0 .. n-1 (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_out_reg
//  Brief    : One-entry ready/valid output register. The producer loads only
//             when the slot is empty or is being drained in the same cycle;
//             contents are held stable while valid && !ready.
//  Revision : 1.0  initial release
// ============================================================================
module stream_out_reg #(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Load wins over drain so back-to-back words need no bubble
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pdetect_frame_pack.sv
`default_nettype none
// ============================================================================
//  Module   : pdetect_frame_pack
//  Brief    : Hunts for sync, then packs PAYLOAD_BYTES bytes big-endian into
//             32-bit words on a ready/valid stream with a frame-last flag.
//             Counts completed frames and pulses o_resync on aborted frames.
//  Revision : 1.0  initial release
// ============================================================================
module pdetect_frame_pack
    import pdetect_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_m_data,
    input  logic        i_m_valid,
    output logic        o_m_ready,
    input  logic        i_sync,
    output logic [31:0] o_s_data,
    output logic        o_s_valid,
    input  logic        i_s_ready,
    output logic        o_s_last,
    output logic [15:0] o_frame_count,
    output logic        o_resync
);

    localparam int                 c_idx_w    = idx_width(PAYLOAD_BYTES);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PAYLOAD_BYTES - 1);

    generate
        if ((PAYLOAD_BYTES % BYTES_PER_WORD) != 0 || PAYLOAD_BYTES < BYTES_PER_WORD) begin : g_bad_payload
            $error("PAYLOAD_BYTES must be a multiple of 4 and at least 4");
        end
    endgenerate

    frame_state_t         r_state;
    logic [c_idx_w-1:0]   r_idx;
    logic [23:0]          r_asm;          // lanes 0..2; lane 3 goes straight out
    logic [15:0]          r_frame_count;
    logic                 r_resync;

    logic [1:0]  w_lane;
    logic        w_accept;
    logic        w_last_byte;
    logic        w_restart;
    logic        w_word_done;
    logic [32:0] w_out;

    assign w_lane = r_idx[1:0];

    // Only a lane-3 byte needs the output slot, so only it can be stalled
    assign o_m_ready   = (r_state == HUNT) ||
                         !((w_lane == 2'd3) && o_s_valid && !i_s_ready);
    assign w_accept    = i_m_valid && o_m_ready;
    // A sync arriving with the final byte lets that frame finish normally
    assign w_last_byte = (r_state == PAYLOAD) && w_accept && (r_idx == c_last_idx);
    assign w_restart   = i_sync && !w_last_byte;
    assign w_word_done = (r_state == PAYLOAD) && !w_restart && w_accept && (w_lane == 2'd3);

    // Framing state, byte index, word assembly, frame counter and resync pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_idx         <= '0;
            r_asm         <= '0;
            r_frame_count <= '0;
            r_resync      <= 1'b0;
        end else begin
            r_resync <= 1'b0;
            if (w_restart) begin
                // New frame; a byte accepted now is payload byte 0
                r_state  <= PAYLOAD;
                r_resync <= (r_state == PAYLOAD);
                r_asm    <= w_accept ? {i_m_data, 16'h0000} : 24'h000000;
                r_idx    <= w_accept ? c_idx_w'(1) : '0;
            end else if ((r_state == PAYLOAD) && w_accept) begin
                case (w_lane)
                    2'd0:    r_asm[23:16] <= i_m_data;
                    2'd1:    r_asm[15:8]  <= i_m_data;
                    2'd2:    r_asm[7:0]   <= i_m_data;
                    default: ;
                endcase
                if (w_last_byte) begin
                    r_frame_count <= r_frame_count + 16'd1;
                    r_idx         <= '0;
                    r_state       <= i_sync ? PAYLOAD : HUNT;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
        end
    end

    stream_out_reg #(
        .WIDTH (33)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_word_done),
        .i_data  ({(r_idx == c_last_idx), r_asm, i_m_data}),
        .i_ready (i_s_ready),
        .o_valid (o_s_valid),
        .o_data  (w_out)
    );

    assign o_s_data      = w_out[31:0];
    assign o_s_last      = w_out[32];
    assign o_frame_count = r_frame_count;
    assign o_resync      = r_resync;

endmodule
`default_nettype wire

// File: tb/tb_pdetect_frame_pack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pdetect_frame_pack
//  Brief    : Self-checking bench for pdetect_frame_pack (PAYLOAD_BYTES = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pdetect_frame_pack;

    localparam int PB = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_m_data;
    logic        i_m_valid;
    logic        o_m_ready;
    logic        i_sync;
    logic [31:0] o_s_data;
    logic        o_s_valid;
    logic        i_s_ready;
    logic        o_s_last;
    logic [15:0] o_frame_count;
    logic        o_resync;

    int errors = 0;
    int checks = 0;

    pdetect_frame_pack #(.PAYLOAD_BYTES(PB)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_m_data      (i_m_data),
        .i_m_valid     (i_m_valid),
        .o_m_ready     (o_m_ready),
        .i_sync        (i_sync),
        .o_s_data      (o_s_data),
        .o_s_valid     (o_s_valid),
        .i_s_ready     (i_s_ready),
        .o_s_last      (o_s_last),
        .o_frame_count (o_frame_count),
        .o_resync      (o_resync)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural reference model ----------------
    bit          m_in_frame;
    logic [7:0]  m_frame[$];      // bytes of the frame collected so far
    bit          m_slot_v;
    logic [31:0] m_slot_d;
    logic        m_slot_l;
    logic [15:0] m_count;
    bit          m_resync;

    logic [31:0] got[$];          // words delivered by handshake
    int          resync_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_frame.delete();
        m_slot_v = 0; m_slot_d = '0; m_slot_l = 1'b0;
        m_count = '0; m_resync = 0;
    endtask

    // A byte stalls only when it completes a word while the slot cannot drain
    function automatic bit exp_ready();
        if (!m_in_frame) return 1'b1;
        return !(((m_frame.size() % 4) == 3) && m_slot_v && !i_s_ready);
    endfunction

    task automatic emit(input bit last);
        int n;
        n = m_frame.size();
        m_slot_d = {m_frame[n-4], m_frame[n-3], m_frame[n-2], m_frame[n-1]};
        m_slot_l = last;
        m_slot_v = 1;
    endtask

    task automatic model_check();
        check("m_ready", {31'd0, o_m_ready}, {31'd0, exp_ready()});
        check("s_valid", {31'd0, o_s_valid}, {31'd0, m_slot_v});
        check("s_data", o_s_data, m_slot_d);
        check("s_last", {31'd0, o_s_last}, {31'd0, m_slot_l});
        check("frame_count", {16'd0, o_frame_count}, {16'd0, m_count});
        check("resync", {31'd0, o_resync}, {31'd0, m_resync});
        if (o_s_valid && i_s_ready) got.push_back(o_s_data);
        if (o_resync) resync_seen++;
    endtask

    task automatic model_step();
        bit acc;
        acc = i_m_valid && exp_ready();
        m_resync = 0;
        if (m_slot_v && i_s_ready) m_slot_v = 0;
        if (!m_in_frame) begin
            if (i_sync) begin
                m_in_frame = 1;
                m_frame.delete();
                if (acc) m_frame.push_back(i_m_data);
            end
        end else if (acc && m_frame.size() == PB - 1) begin
            m_frame.push_back(i_m_data);
            emit(1'b1);
            m_count = m_count + 16'd1;
            m_frame.delete();
            m_in_frame = i_sync;
        end else if (i_sync) begin
            m_resync = 1;
            m_frame.delete();
            if (acc) m_frame.push_back(i_m_data);
        end else if (acc) begin
            m_frame.push_back(i_m_data);
            if ((m_frame.size() % 4) == 0) emit(1'b0);
        end
    endtask

    // One clock: drive, check before the edge, advance the model on the edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic r);
        i_m_valid = v; i_m_data = d; i_sync = s; i_s_ready = r;
        @(negedge i_clk);
        model_check();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < PB; k++) cyc(1'b1, base + 8'(k), 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic check_words(input string name, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2, input int n);
        logic [31:0] exp_w[3];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
        check({name, "_nwords"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++) check({name, "_word"}, got[k], exp_w[k]);
    endtask

    // ---------------- directed table for the basic frame ----------------
    typedef struct {
        logic        sync;
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_dat;
        logic        e_last;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[11];

    initial begin
        int c0;
        vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vt[1]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vt[2]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vt[3]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vt[4]  = '{1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 16'd0};
        vt[5]  = '{1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 1'b1, 32'h11121314, 1'b0, 16'd0};
        vt[6]  = '{1'b0, 1'b1, 8'h16, 1'b1, 1'b1, 1'b0, 32'h11121314, 1'b0, 16'd0};
        vt[7]  = '{1'b0, 1'b1, 8'h17, 1'b1, 1'b1, 1'b0, 32'h11121314, 1'b0, 16'd0};
        vt[8]  = '{1'b0, 1'b1, 8'h18, 1'b1, 1'b1, 1'b0, 32'h11121314, 1'b0, 16'd0};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h15161718, 1'b1, 16'd1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h15161718, 1'b1, 16'd1};

        // Reset values
        i_rst = 1'b1; i_m_valid = 0; i_m_data = 0; i_sync = 0; i_s_ready = 0;
        model_reset();
        #3;
        check("rst_valid", {31'd0, o_s_valid}, 32'd0);
        check("rst_last", {31'd0, o_s_last}, 32'd0);
        check("rst_data", o_s_data, 32'd0);
        check("rst_count", {16'd0, o_frame_count}, 32'd0);
        check("rst_resync", {31'd0, o_resync}, 32'd0);
        check("rst_ready", {31'd0, o_m_ready}, 32'd1);
        @(negedge i_clk); i_rst = 1'b0;
        @(posedge i_clk); #1;

        // 1. Basic frame, latency and count from the table
        for (int i = 0; i < 11; i++) begin
            i_sync = vt[i].sync; i_m_valid = vt[i].v; i_m_data = vt[i].d; i_s_ready = vt[i].r;
            @(negedge i_clk);
            model_check();
            check("t1_ready", {31'd0, o_m_ready}, {31'd0, vt[i].e_rdy});
            check("t1_valid", {31'd0, o_s_valid}, {31'd0, vt[i].e_val});
            check("t1_data", o_s_data, vt[i].e_dat);
            check("t1_last", {31'd0, o_s_last}, {31'd0, vt[i].e_last});
            check("t1_count", {16'd0, o_frame_count}, {16'd0, vt[i].e_cnt});
            @(posedge i_clk);
            model_step();
            #1;
        end

        // 2. Bytes before sync are discarded
        got.delete();
        cyc(1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        cyc(1'b1, 8'hCC, 1'b0, 1'b1);
        send_frame(8'h01);
        check_words("t2", 32'h01020304, 32'h05060708, 32'h0, 2);

        // 3. Backpressure: final lane-3 byte stalls while first word is pending
        got.delete();
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            i_m_valid = 1'b1; i_m_data = 8'h18; i_s_ready = 1'b0; i_sync = 1'b0;
            #1;
            check("t3_stall_ready", {31'd0, o_m_ready}, 32'd0);
            check("t3_hold_data", o_s_data, 32'h11121314);
            cyc(1'b1, 8'h18, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'h18, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check_words("t3", 32'h11121314, 32'h15161718, 32'h0, 2);

        // 4. Resync aborts a partial frame
        got.delete(); resync_seen = 0; c0 = int'(o_frame_count);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) cyc(1'b1, 8'h21 + 8'(k), 1'b0, 1'b1);
        send_frame(8'h31);
        check_words("t4", 32'h21222324, 32'h31323334, 32'h35363738, 3);
        check("t4_resync_pulses", resync_seen, 1);
        check("t4_count_delta", int'(o_frame_count) - c0, 1);

        // 5. Asynchronous reset mid-frame
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'h01 + 8'(k), 1'b0, 1'b1);
        i_m_valid = 0; i_sync = 0; i_s_ready = 0;
        i_rst = 1'b1;
        #1;
        check("t5_valid", {31'd0, o_s_valid}, 32'd0);
        check("t5_data", o_s_data, 32'd0);
        check("t5_count", {16'd0, o_frame_count}, 32'd0);
        check("t5_ready", {31'd0, o_m_ready}, 32'd1);
        model_reset();
        @(negedge i_clk); i_rst = 1'b0;
        @(posedge i_clk); #1;
        got.delete();
        send_frame(8'h41);
        check_words("t5", 32'h41424344, 32'h45464748, 32'h0, 2);
        check("t5_count_after", {16'd0, o_frame_count}, 32'd1);

        // 6. Frame counter wrap
        force dut.r_frame_count = 16'hFFFE;
        #1;
        release dut.r_frame_count;
        m_count = 16'hFFFE;
        send_frame(8'h51);
        check("t6_count_ffff", {16'd0, o_frame_count}, 32'h0000FFFF);
        send_frame(8'h61);
        check("t6_count_wrap", {16'd0, o_frame_count}, 32'h00000000);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
